icache_sa: RTL and testbench

- Parametrised set-associative instruction cache with multi-word lines, the successor to the direct-mapped single-word icache.
- Sits between IFetch and MemCtrl.
- Serves hits one cycle after request.
- On a miss, refills a whole line word-by-word from MemCtrl through a small FSM, with per-set round-robin replacement.
- Adds a whole-cache invalidate for fence.i.

---
 rtl/icache_sa_pkg.sv | 17 +
 rtl/icache_way.sv | 56 +++++
 rtl/icache_sa.sv | 150 +++++++++++++++
 tb/tb_icache_sa.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_sa_pkg.sv
// Shared constants for the set-associative instruction cache: boolean
// literals, refill FSM state encodings and default geometry.
package icache_sa_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam int DEF_WAYS       = 2;
    localparam int DEF_SETS       = 16;
    localparam int DEF_LINE_WORDS = 4;

    typedef enum logic {
        IC_IDLE   = 1'b0,
        IC_REFILL = 1'b1
    } ic_state_t;

endpackage

// File: rtl/icache_way.sv
// One way of the instruction cache: per-set valid bit, tag and line data,
// with a combinational read port and tag compare for the requesting set.
module icache_way #(
    parameter int SETS       = 16,
    parameter int LINE_WORDS = 4,
    parameter int IDX_W      = 4,
    parameter int OW         = 2,
    parameter int TAG_W      = 24
)(
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic [OW-1:0]    rd_off,
    input  logic [TAG_W-1:0] rd_tag,
    output logic             hit,
    output logic             rd_valid,
    output logic [31:0]      rd_word,
    input  logic             inv_all,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [OW-1:0]    wr_off,
    input  logic [31:0]      wr_data,
    input  logic             line_wr,
    input  logic             line_valid,
    input  logic [TAG_W-1:0] wr_tag
);

    logic [SETS-1:0]  valid;
    logic [TAG_W-1:0] tags [SETS];
    logic [31:0]      data [SETS][LINE_WORDS];

    assign rd_valid = valid[rd_idx];
    assign hit      = valid[rd_idx] && (tags[rd_idx] == rd_tag);
    assign rd_word  = data[rd_idx][rd_off];

    // Invalidate-all wins over a completing line so fence.i can never be lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= '0;
        end else if (inv_all) begin
            valid <= '0;
        end else if (line_wr) begin
            valid[wr_idx] <= line_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            data[wr_idx][wr_off] <= wr_data;
        end
        if (line_wr) begin
            tags[wr_idx] <= wr_tag;
        end
    end

endmodule

// File: rtl/icache_sa.sv
// Set-associative instruction cache between IFetch and MemCtrl: one-cycle
// hits, word-by-word line refill on a miss, round-robin victim per set.
module icache_sa
    import icache_sa_pkg::*;
#(
    parameter int WAYS       = DEF_WAYS,
    parameter int SETS       = DEF_SETS,
    parameter int LINE_WORDS = DEF_LINE_WORDS
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        full,
    input  logic        rollback,
    input  logic        inv_all,
    input  logic [31:0] IF_addr,
    input  logic        IF_addr_sgn,
    output logic [31:0] IF_val,
    output logic        IF_val_sgn,
    output logic [31:0] Mc_addr,
    output logic        Mc_addr_sgn,
    input  logic [31:0] MC_val,
    input  logic        MC_val_sgn
);

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 32 - OFF_W - IDX_W - 2;
    localparam int OW    = (OFF_W > 0) ? OFF_W : 1;
    localparam int WW    = (WAYS > 1) ? $clog2(WAYS) : 1;

    ic_state_t        state, state_next;
    logic [TAG_W-1:0] fill_tag;
    logic [IDX_W-1:0] fill_idx;
    logic [WW-1:0]    victim, victim_sel;
    logic [OW-1:0]    cnt;
    logic             kill;
    logic [WW-1:0]    rr [SETS];

    logic [OW-1:0]    req_off;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic [WAYS-1:0]  way_hit, way_valid;
    logic [31:0]      way_word [WAYS];
    logic             hit, refill_wr, last_word, start_fill, respond, found;
    logic [31:0]      hit_word;

    assign req_off = OW'((IF_addr >> 2) & 32'(LINE_WORDS - 1));
    assign req_idx = IDX_W'(IF_addr >> (OFF_W + 2));
    assign req_tag = TAG_W'(IF_addr >> (OFF_W + IDX_W + 2));

    assign refill_wr  = rdy && (state == IC_REFILL) && MC_val_sgn;
    assign last_word  = (cnt == OW'(LINE_WORDS - 1));
    assign start_fill = (state == IC_IDLE) && IF_addr_sgn && !rollback && !hit;
    assign respond    = (state == IC_IDLE) && IF_addr_sgn && !rollback && hit && !full;

    assign Mc_addr     = (32'({fill_tag, fill_idx}) << (OFF_W + 2))
                       | ((32'(cnt) & 32'(LINE_WORDS - 1)) << 2);
    assign Mc_addr_sgn = (state == IC_REFILL) && !MC_val_sgn;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        icache_way #(
            .SETS(SETS), .LINE_WORDS(LINE_WORDS), .IDX_W(IDX_W), .OW(OW), .TAG_W(TAG_W)
        ) u_way (
            .clk(clk), .rst(rst),
            .rd_idx(req_idx), .rd_off(req_off), .rd_tag(req_tag),
            .hit(way_hit[w]), .rd_valid(way_valid[w]), .rd_word(way_word[w]),
            .inv_all(rdy && inv_all),
            .wr_en(refill_wr && (victim == WW'(w))),
            .wr_idx(fill_idx), .wr_off(cnt), .wr_data(MC_val),
            .line_wr(refill_wr && last_word && (victim == WW'(w))),
            .line_valid(!kill), .wr_tag(fill_tag)
        );
    end

    // Fill guarantees at most one matching way, so OR-ing the words is a mux.
    always_comb begin
        hit        = FALSE;
        hit_word   = '0;
        victim_sel = rr[req_idx];
        found      = FALSE;
        for (int w = 0; w < WAYS; w++) begin
            if (way_hit[w]) begin
                hit      = TRUE;
                hit_word = hit_word | way_word[w];
            end
            if (!way_valid[w] && !found) begin
                victim_sel = WW'(w);
                found      = TRUE;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IC_IDLE:   if (start_fill) state_next = IC_REFILL;
            IC_REFILL: if (MC_val_sgn && last_word) state_next = IC_IDLE;
            default:   state_next = IC_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IC_IDLE;
        end else if (rdy) begin
            state <= state_next;
        end
    end

    // kill remembers an inv_all seen mid-refill so the arriving line stays invalid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            IF_val     <= '0;
            IF_val_sgn <= FALSE;
            fill_tag   <= '0;
            fill_idx   <= '0;
            victim     <= '0;
            cnt        <= '0;
            kill       <= FALSE;
            for (int s = 0; s < SETS; s++) rr[s] <= '0;
        end else begin
            IF_val_sgn <= FALSE;
            if (rdy) begin
                if (respond) begin
                    IF_val     <= hit_word;
                    IF_val_sgn <= TRUE;
                end
                if (start_fill) begin
                    fill_tag <= req_tag;
                    fill_idx <= req_idx;
                    victim   <= victim_sel;
                    cnt      <= '0;
                    kill     <= FALSE;
                end else if (state == IC_REFILL) begin
                    if (refill_wr) begin
                        cnt <= cnt + OW'(1);
                    end
                    if (refill_wr && last_word) begin
                        rr[fill_idx] <= (WAYS > 1) ? rr[fill_idx] + WW'(1) : '0;
                        kill         <= FALSE;
                    end else if (inv_all) begin
                        kill <= TRUE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_icache_sa.sv
// Self-checking bench for icache_sa: MemCtrl model with 3-cycle word latency,
// scoreboard of expected instructions, table-driven fetches plus corner cases.
module tb_icache_sa;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic        full = 1'b0;
    logic        rollback = 1'b0;
    logic        inv_all = 1'b0;
    logic [31:0] IF_addr = '0;
    logic        IF_addr_sgn = 1'b0;
    logic [31:0] IF_val;
    logic        IF_val_sgn;
    logic [31:0] Mc_addr;
    logic        Mc_addr_sgn;
    logic [31:0] MC_val = '0;
    logic        MC_val_sgn = 1'b0;

    int compared = 0;
    int failed = 0;
    logic [31:0] sb[$];

    typedef struct {
        logic [31:0] addr;
        logic        exp_hit;
        string       name;
    } vec_t;
    vec_t vecs[14];

    icache_sa dut (
        .clk(clk), .rst(rst), .rdy(rdy), .full(full), .rollback(rollback),
        .inv_all(inv_all), .IF_addr(IF_addr), .IF_addr_sgn(IF_addr_sgn),
        .IF_val(IF_val), .IF_val_sgn(IF_val_sgn), .Mc_addr(Mc_addr),
        .Mc_addr_sgn(Mc_addr_sgn), .MC_val(MC_val), .MC_val_sgn(MC_val_sgn)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return {a[15:0] ^ 16'hC0DE, a[15:0]};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // MemCtrl model: latches a request, answers three cycles later, frozen by !rdy.
    logic        mem_busy = 1'b0;
    int          mem_lat = 0;
    logic [31:0] mem_addr = '0;
    always @(posedge clk) begin
        logic        sgn_now;
        logic [31:0] addr_now;
        #2;
        sgn_now  = Mc_addr_sgn;
        addr_now = Mc_addr;
        MC_val_sgn = 1'b0;
        if (!rst) begin
            mem_busy = 1'b0;
        end else if (mem_busy) begin
            if (sgn_now) checkOutput("mc_addr stable", addr_now, mem_addr);
            if (rdy) mem_lat++;
            if (mem_lat == 3) begin
                MC_val     = memword(mem_addr);
                MC_val_sgn = 1'b1;
                mem_busy   = 1'b0;
            end
        end else if (sgn_now && rdy) begin
            mem_busy = 1'b1;
            mem_lat  = 0;
            mem_addr = addr_now;
        end
    end

    always @(negedge clk) begin
        if (rst && IF_val_sgn) begin
            compared++;
            if (sb.size() == 0) begin
                failed++;
                $display("[TB] FAIL unexpected response: got %h, expected none", IF_val);
            end else begin
                logic [31:0] exp;
                exp = sb.pop_front();
                if (IF_val !== exp) begin
                    failed++;
                    $display("[TB] FAIL if_val: got %h, expected %h", IF_val, exp);
                end
            end
        end
    end

    // Full fetch: held until answered; a cold miss takes 21 cycles with this MemCtrl.
    task automatic applyStimulus(input logic [31:0] addr, input logic exp_hit, input string name);
        int   cycles;
        logic saw_mc;
        logic done;
        sb.push_back(memword(addr & ~32'h3));
        IF_addr     = addr;
        IF_addr_sgn = 1'b1;
        cycles = 0;
        saw_mc = 1'b0;
        done   = 1'b0;
        while (!done && cycles < 400) begin
            @(negedge clk);
            cycles++;
            if (Mc_addr_sgn) saw_mc = 1'b1;
            if (IF_val_sgn) done = 1'b1;
        end
        IF_addr_sgn = 1'b0;
        checkOutput({name, " done"}, 32'(done), 32'd1);
        if (!done) sb.delete();
        checkOutput({name, " latency"}, 32'(cycles), exp_hit ? 32'd1 : 32'd21);
        checkOutput({name, " mc_req"}, 32'(saw_mc), 32'(!exp_hit));
    endtask

    task automatic waitPulses(input int n, input string name);
        int got = 0;
        int cyc = 0;
        while (got < n && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (MC_val_sgn) got++;
        end
        checkOutput(name, 32'(got), 32'(n));
    endtask

    task automatic waitResponse(input string name);
        int cyc = 0;
        while (!IF_val_sgn && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        IF_addr_sgn = 1'b0;
        checkOutput(name, 32'(IF_val_sgn), 32'd1);
    endtask

    task automatic rollbackIdle(input logic [31:0] addr, input string name);
        IF_addr     = addr;
        IF_addr_sgn = 1'b1;
        rollback    = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput({name, " if_val_sgn"}, 32'(IF_val_sgn), 32'd0);
            checkOutput({name, " mc_addr_sgn"}, 32'(Mc_addr_sgn), 32'd0);
        end
        IF_addr_sgn = 1'b0;
        rollback    = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int got;
        vecs[0]  = '{32'h100, 1'b0, "cold 0x100"};
        vecs[1]  = '{32'h104, 1'b1, "hit 0x104"};
        vecs[2]  = '{32'h108, 1'b1, "hit 0x108"};
        vecs[3]  = '{32'h10C, 1'b1, "hit 0x10C"};
        vecs[4]  = '{32'h200, 1'b0, "fill 0x200"};
        vecs[5]  = '{32'h300, 1'b0, "evict 0x300"};
        vecs[6]  = '{32'h204, 1'b1, "rehit 0x204"};
        vecs[7]  = '{32'h100, 1'b0, "evicted 0x100"};
        vecs[8]  = '{32'h30C, 1'b1, "hit 0x30C"};
        vecs[9]  = '{32'h208, 1'b0, "evicted 0x208"};
        vecs[10] = '{32'h014, 1'b0, "set1 0x014"};
        vecs[11] = '{32'h018, 1'b1, "set1 0x018"};
        vecs[12] = '{32'h01B, 1'b1, "low bits 0x01B"};
        vecs[13] = '{32'h104, 1'b1, "way1 0x104"};

        @(negedge clk);
        checkOutput("reset if_val", IF_val, 32'h0);
        checkOutput("reset if_val_sgn", 32'(IF_val_sgn), 32'd0);
        checkOutput("reset mc_addr", Mc_addr, 32'h0);
        checkOutput("reset mc_addr_sgn", 32'(Mc_addr_sgn), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) applyStimulus(vecs[i].addr, vecs[i].exp_hit, vecs[i].name);

        // Rollback during the second word of 0x400: refill completes silently.
        IF_addr     = 32'h400;
        IF_addr_sgn = 1'b1;
        waitPulses(1, "rb first word");
        rollback    = 1'b1;
        IF_addr_sgn = 1'b0;
        @(negedge clk);
        rollback = 1'b0;
        waitPulses(3, "rb remaining words");
        repeat (3) @(negedge clk);
        applyStimulus(32'h404, 1'b1, "after rb 0x404");

        rollbackIdle(32'h800, "rb idle miss");

        // inv_all mid-refill: killed line forces a second refill of 0x500.
        sb.push_back(memword(32'h500));
        IF_addr     = 32'h500;
        IF_addr_sgn = 1'b1;
        waitPulses(1, "inv first word");
        inv_all = 1'b1;
        @(negedge clk);
        inv_all = 1'b0;
        got = 0;
        for (int c = 0; c < 300 && !IF_val_sgn; c++) begin
            if (MC_val_sgn) got++;
            @(negedge clk);
        end
        IF_addr_sgn = 1'b0;
        checkOutput("inv refill words", 32'(got), 32'd7);
        checkOutput("inv response", 32'(IF_val_sgn), 32'd1);
        applyStimulus(32'h018, 1'b0, "after inv 0x018");
        applyStimulus(32'h500, 1'b1, "after inv 0x500");

        // full held 5 cycles over a hit.
        sb.push_back(memword(32'h504));
        IF_addr     = 32'h504;
        IF_addr_sgn = 1'b1;
        full        = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("full held", 32'(IF_val_sgn), 32'd0);
        end
        full = 1'b0;
        @(negedge clk);
        checkOutput("full released", 32'(IF_val_sgn), 32'd1);
        IF_addr_sgn = 1'b0;
        @(negedge clk);

        rollbackIdle(32'h508, "rb idle hit");

        // rdy low for 3 cycles in the middle of the 0x600 refill.
        sb.push_back(memword(32'h600));
        IF_addr     = 32'h600;
        IF_addr_sgn = 1'b1;
        waitPulses(1, "rdy first word");
        @(negedge clk);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("rdy frozen mc_addr", Mc_addr, 32'h604);
            checkOutput("rdy frozen mc_addr_sgn", 32'(Mc_addr_sgn), 32'd1);
            @(negedge clk);
        end
        rdy = 1'b1;
        waitResponse("rdy refill response");
        @(negedge clk);

        // Asynchronous reset in the middle of the 0x700 refill.
        IF_addr     = 32'h700;
        IF_addr_sgn = 1'b1;
        waitPulses(1, "rst first word");
        rst = 1'b0;
        #1;
        checkOutput("rst if_val", IF_val, 32'h0);
        checkOutput("rst if_val_sgn", 32'(IF_val_sgn), 32'd0);
        checkOutput("rst mc_addr", Mc_addr, 32'h0);
        checkOutput("rst mc_addr_sgn", 32'(Mc_addr_sgn), 32'd0);
        IF_addr_sgn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        applyStimulus(32'h700, 1'b0, "after rst 0x700");
        applyStimulus(32'h104, 1'b0, "after rst 0x104");

        repeat (3) @(negedge clk);
        checkOutput("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
